// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised synchronous FIFO with a registered read port, one-cycle
// write/read handshake flags, almost-full/almost-empty thresholds and a
// synchronous flush. Storage is a plain register array addressed by
// head/tail pointers; occupancy is tracked by an explicit counter so that
// full and empty are unambiguous when head == tail.

`timescale 1ns/1ps

module fifo_sync_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int AF_LVL     = 28,
  parameter int AE_LVL     = 4,
  parameter int CLEAR_DOUT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [ADDR_W:0]   data_count
);

  localparam int DEPTH = 1 << ADDR_W;

  // Thresholds sized to the counter so comparisons carry no width mismatch.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_LVL[ADDR_W:0];

  // Outcome of the last request edge. The RW_ERR family covers every mix in
  // which at least one side of a simultaneous read+write was rejected.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,  // no request
    ST_WR      = 4'd1,  // write accepted
    ST_RD      = 4'd2,  // read accepted
    ST_RW      = 4'd3,  // write and read accepted
    ST_WR_ERR  = 4'd4,  // write rejected
    ST_RD_ERR  = 4'd5,  // read rejected
    ST_RW_ERR  = 4'd6,  // write and read rejected
    ST_RW_RERR = 4'd7,  // write accepted, read rejected
    ST_RW_WERR = 4'd8   // write rejected, read accepted
  } status_e;

  // Per-side request outcome used to build the next status.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_ACK  = 2'b01,
    REQ_ERR  = 2'b10
  } req_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  status_e           status_q, status_d;

  logic rd_ok;
  logic wr_ok;
  req_e wr_res;
  req_e rd_res;

  // Accept/reject decision for this edge; clear suppresses both sides.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (!clear) begin
      rd_ok = rd_en && (count_q != '0);
      // A full FIFO still accepts a write when a read frees a slot this edge.
      wr_ok = wr_en && ((count_q != DEPTH_C) || rd_ok);
    end
  end

  // Pointer, count and read-data next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = (CLEAR_DOUT != 0) ? '0 : dout_q;

    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      dout_d  = '0;
    end else begin
      if (rd_ok) begin
        dout_d = mem[head_q];
        head_d = head_q + ADDR_W'(1);
      end
      if (wr_ok) begin
        tail_d = tail_q + ADDR_W'(1);
      end
      // Simultaneous accepted read and write leave the count unchanged.
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Classify each side of the request, then fold into a status code.
  always_comb begin
    wr_res   = REQ_NONE;
    rd_res   = REQ_NONE;
    status_d = ST_IDLE;

    if (!clear) begin
      if (wr_en) wr_res = wr_ok ? REQ_ACK : REQ_ERR;
      if (rd_en) rd_res = rd_ok ? REQ_ACK : REQ_ERR;
    end

    unique case ({wr_res, rd_res})
      {REQ_NONE, REQ_NONE}: status_d = ST_IDLE;
      {REQ_ACK,  REQ_NONE}: status_d = ST_WR;
      {REQ_NONE, REQ_ACK }: status_d = ST_RD;
      {REQ_ACK,  REQ_ACK }: status_d = ST_RW;
      {REQ_ERR,  REQ_NONE}: status_d = ST_WR_ERR;
      {REQ_NONE, REQ_ERR }: status_d = ST_RD_ERR;
      {REQ_ERR,  REQ_ERR }: status_d = ST_RW_ERR;
      {REQ_ACK,  REQ_ERR }: status_d = ST_RW_RERR;
      {REQ_ERR,  REQ_ACK }: status_d = ST_RW_WERR;
      default:              status_d = ST_IDLE;
    endcase
  end

  // Control state: pointers, count, read register and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      status_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // pre-edge values; a full-FIFO read+write reads the old head entry.
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      status_q <= status_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the count guarantees an entry is written
    // before it can be read, and leaving it unreset lets it map onto RAM.
    if (wr_ok) begin
      mem[tail_q] <= din;
    end
  end

  // Handshake flags decoded from the registered status.
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    unique case (status_q)
      ST_IDLE:    ;
      ST_WR:      wr_ack = 1'b1;
      ST_RD:      rd_ack = 1'b1;
      ST_RW:      begin wr_ack = 1'b1; rd_ack = 1'b1; end
      ST_WR_ERR:  wr_err = 1'b1;
      ST_RD_ERR:  rd_err = 1'b1;
      ST_RW_ERR:  begin wr_err = 1'b1; rd_err = 1'b1; end
      ST_RW_RERR: begin wr_ack = 1'b1; rd_err = 1'b1; end
      ST_RW_WERR: begin wr_err = 1'b1; rd_ack = 1'b1; end
      default:    ;
    endcase
  end

  // Occupancy status derived from the registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign data_count   = count_q;
  assign dout         = dout_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench for fifo_sync_param (default parameters).
// A queue-based reference model tracks the expected contents and flags;
// a vector table, directed corner sequences and a randomised run follow.

`timescale 1ns/1ps

module tb_fifo_sync_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int AF_LVL = 28;
  localparam int AE_LVL = 4;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full, empty, almost_full, almost_empty;
  logic              wr_ack, wr_err, rd_ack, rd_err;
  logic [ADDR_W:0]   data_count;

  int checks = 0;
  int errors = 0;

  fifo_sync_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .CLEAR_DOUT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
    .data_count(data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: FIFO contents as a queue, flags as plain bits.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_dout;
  bit m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
  endtask

  task automatic model_step(input bit c, input bit w, input bit r, input logic [DATA_W-1:0] d);
    bit can_rd, can_wr;
    if (c) begin
      model_reset();
      return;
    end
    can_rd = r && (mq.size() > 0);
    can_wr = w && ((mq.size() < DEPTH) || can_rd);
    m_dout = '0;
    if (can_rd) m_dout = mq.pop_front();
    if (can_wr) mq.push_back(d);
    m_wr_ack = can_wr;
    m_wr_err = w && !can_wr;
    m_rd_ack = can_rd;
    m_rd_err = r && !can_rd;
  endtask

  task automatic compare_model(input string tag);
    int sz;
    sz = mq.size();
    check({tag, " count"}, 64'(data_count), 64'(sz));
    check({tag, " dout"}, 64'(dout), 64'(m_dout));
    check({tag, " full"}, 64'(full), 64'(sz == DEPTH));
    check({tag, " empty"}, 64'(empty), 64'(sz == 0));
    check({tag, " almost_full"}, 64'(almost_full), 64'(sz >= AF_LVL));
    check({tag, " almost_empty"}, 64'(almost_empty), 64'(sz <= AE_LVL));
    check({tag, " flags"}, 64'({wr_ack, wr_err, rd_ack, rd_err}),
          64'({m_wr_ack, m_wr_err, m_rd_ack, m_rd_err}));
  endtask

  // Drive one request cycle, advance the model, and sample after the edge.
  task automatic tick(input bit c, input bit w, input bit r, input logic [DATA_W-1:0] d);
    clear = c; wr_en = w; rd_en = r; din = d;
    model_step(c, w, r, d);
    @(posedge clk);
    #1;
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " count"}, 64'(data_count), 64'd0);
    check({tag, " dout"}, 64'(dout), 64'd0);
    check({tag, " status"}, 64'({full, empty, almost_full, almost_empty}), 64'b0101);
    check({tag, " flags"}, 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'b0000);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit              clr, wr, rd;
    logic [DATA_W-1:0] din;
    logic [ADDR_W:0] exp_count;
    logic [3:0]      exp_flags;  // {wr_ack, wr_err, rd_ack, rd_err}
    logic [DATA_W-1:0] exp_dout;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #3;
    do_reset();

    // Read on an empty FIFO straight after reset.
    tick(0, 0, 1, 32'h0);
    check("t1 rd_err", 64'(rd_err), 64'd1);
    check("t1 dout", 64'(dout), 64'd0);
    check("t1 empty", 64'(empty), 64'd1);
    check("t1 count", 64'(data_count), 64'd0);

    // Vector table, starting from empty.
    vecs[0] = '{0, 0, 1, 32'h00, 6'd0, 4'b0001, 32'h00};
    vecs[1] = '{0, 1, 0, 32'h11, 6'd1, 4'b1000, 32'h00};
    vecs[2] = '{0, 1, 0, 32'h22, 6'd2, 4'b1000, 32'h00};
    vecs[3] = '{0, 1, 1, 32'h33, 6'd2, 4'b1010, 32'h11};
    vecs[4] = '{0, 0, 0, 32'h00, 6'd2, 4'b0000, 32'h00};
    vecs[5] = '{0, 0, 1, 32'h00, 6'd1, 4'b0010, 32'h22};
    vecs[6] = '{1, 1, 1, 32'h44, 6'd0, 4'b0000, 32'h00};
    vecs[7] = '{0, 1, 1, 32'h55, 6'd1, 4'b1001, 32'h00};
    vecs[8] = '{0, 0, 1, 32'h00, 6'd0, 4'b0010, 32'h55};
    vecs[9] = '{0, 0, 0, 32'h00, 6'd0, 4'b0000, 32'h00};
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d count", i), 64'(data_count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d flags", i), 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'(vecs[i].exp_flags));
      check($sformatf("vec%0d dout", i), 64'(dout), 64'(vecs[i].exp_dout));
    end

    // Fill to full, then overflow.
    for (int i = 1; i <= 32; i++) begin
      tick(0, 1, 0, DATA_W'(i));
      check($sformatf("t2 af at %0d", i), 64'(almost_full), 64'(i >= 28));
      compare_model("t2");
    end
    check("t2 full", 64'(full), 64'd1);
    check("t2 count", 64'(data_count), 64'd32);
    tick(0, 1, 0, 32'h21);
    check("t2 wr_err", 64'(wr_err), 64'd1);
    check("t2 wr_ack", 64'(wr_ack), 64'd0);
    check("t2 count after overflow", 64'(data_count), 64'd32);

    // Drain in order.
    for (int i = 0; i < 32; i++) begin
      tick(0, 0, 1, 32'h0);
      check($sformatf("t3 dout %0d", i), 64'(dout), 64'(i + 1));
      check($sformatf("t3 rd_ack %0d", i), 64'(rd_ack), 64'd1);
      check($sformatf("t3 ae %0d", i), 64'(almost_empty), 64'((31 - i) <= 4));
    end
    check("t3 empty", 64'(empty), 64'd1);

    // Simultaneous read+write at full and at empty.
    for (int i = 0; i < 32; i++) tick(0, 1, 0, 32'h200 + DATA_W'(i));
    tick(0, 1, 1, 32'hAA);
    check("t4 full rw flags", 64'({wr_ack, rd_ack}), 64'b11);
    check("t4 full rw dout", 64'(dout), 64'h200);
    check("t4 full rw count", 64'(data_count), 64'd32);
    for (int i = 0; i < 32; i++) begin
      tick(0, 0, 1, 32'h0);
      compare_model("t4 drain");
    end
    check("t4 last is AA", 64'(dout), 64'hAA);
    tick(0, 1, 1, 32'hBB);
    check("t4 empty rw flags", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'b1001);
    check("t4 empty rw count", 64'(data_count), 64'd1);
    tick(0, 0, 1, 32'h0);
    check("t4 bb out", 64'(dout), 64'hBB);

    // Pointer wrap from a fresh reset.
    do_reset();
    for (int i = 0; i < 20; i++) tick(0, 1, 0, DATA_W'(i));
    for (int i = 0; i < 20; i++) tick(0, 0, 1, 32'h0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 32'h100 + DATA_W'(i));
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 1, 32'h0);
      check($sformatf("t5 wrap %0d", i), 64'(dout), 64'(32'h100 + i));
    end

    // Clear with a same-cycle write.
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 32'h300 + DATA_W'(i));
    check("t6 count 10", 64'(data_count), 64'd10);
    tick(1, 1, 0, 32'h77);
    check("t6 clear count", 64'(data_count), 64'd0);
    check("t6 clear flags", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'b0000);
    check("t6 clear empty", 64'(empty), 64'd1);
    check("t6 clear dout", 64'(dout), 64'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) tick(0, 1, (i > 2), 32'h400 + DATA_W'(i));
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("t6 async reset");
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tick(0, 0, 1, 32'h0);
    check("t6 read after reset rd_err", 64'(rd_err), 64'd1);
    compare_model("t6 post reset");

    // Randomised traffic with write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 600; i++) begin
      int phase;
      bit c, w, r;
      phase = (i / 50) % 3;
      c = ($urandom_range(0, 63) == 0);
      case (phase)
        0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
        1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
        default: begin w = $urandom_range(0, 1) == 1;  r = $urandom_range(0, 1) == 1;  end
      endcase
      tick(c, w, r, $urandom);
      compare_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
